// File: rtl/gcd.sv
//------------------------------------------------------------------------------
// Module  : gcd
// Brief   : Iterative 32-bit GCD engine (Euclid by subtraction), start/done
//           handshake. Optional `busy` output enabled by macro GCD_BUSY_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gcd (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic        done,
    output logic [31:0] result
`ifdef GCD_BUSY_EN
    ,
    output logic        busy
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] reg_a_q, reg_a_d;
    logic [31:0] reg_b_q, reg_b_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;

    always_comb begin
        state_d  = state_q;
        reg_a_d  = reg_a_q;
        reg_b_d  = reg_b_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    reg_a_d = a_in;
                    reg_b_d = b_in;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (reg_b_q == 32'd0) begin
                    result_d = reg_a_q;
                    state_d  = S_DONE;
                end else if (reg_a_q == 32'd0) begin
                    result_d = reg_b_q;
                    state_d  = S_DONE;
                end else if (reg_a_q == reg_b_q) begin
                    result_d = reg_a_q;
                    state_d  = S_DONE;
                end else if (reg_a_q > reg_b_q) begin
                    reg_a_d = reg_a_q - reg_b_q;
                end else begin
                    reg_b_d = reg_b_q - reg_a_q;
                end
            end
            S_DONE: begin
                // Returning to IDLE on this edge also accepts a start seen here.
                state_d = S_IDLE;
                if (start) begin
                    reg_a_d = a_in;
                    reg_b_d = b_in;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            reg_a_q  <= 32'd0;
            reg_b_q  <= 32'd0;
            result_q <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            reg_a_q  <= reg_a_d;
            reg_b_q  <= reg_b_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;

`ifdef GCD_BUSY_EN
    logic busy_q;
    logic busy_d;

    assign busy_d = (state_d != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gcd.sv
//------------------------------------------------------------------------------
// Module  : tb_gcd
// Brief   : Self-checking bench for gcd with a result/latency scoreboard.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_gcd;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        done;
    logic [31:0] result;
`ifdef GCD_BUSY_EN
    logic        busy;
`endif

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          tests;
    int          fails;
    logic [31:0] last_res;

    gcd dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .done    (done),
        .result  (result)
`ifdef GCD_BUSY_EN
        ,
        .busy    (busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: subtraction-based Euclid, also counting subtraction steps.
    task automatic gcd_model(input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] g, output int steps);
        logic [31:0] x;
        logic [31:0] y;
        x = a;
        y = b;
        steps = 0;
        while (x != 0 && y != 0 && x != y) begin
            if (x > y) x = x - y;
            else       y = y - x;
            steps++;
        end
        g = (y == 0) ? x : (x == 0) ? y : x;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit pulse);
        logic [31:0] g;
        int          n;
        int          cyc;
        bit          got;
        bit          hold_bad;
        logic [31:0] hold_seen;
        exp_t        e;
        gcd_model(a, b, g, n);
        sb.push_back('{res: g, lat: n + 1});
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(posedge clk); #1;
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
`ifdef GCD_BUSY_EN
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_run: got %b expected 1", busy);
        end
`endif
        cyc = 0;
        got = 0;
        hold_bad = 0;
        hold_seen = result;
        while (!got && cyc < n + 20) begin
            if (result !== last_res) begin
                hold_bad = 1;
                hold_seen = result;
            end
            start = (pulse && (cyc == 10 || cyc == 50)) ? 1'b1 : 1'b0;
            a_in  = $urandom;
            b_in  = $urandom;
            @(posedge clk); #1;
            cyc++;
            if (done === 1'b1) got = 1;
        end
        start = 1'b0;
        tests++;
        if (hold_bad) begin
            fails++;
            $display("FAIL result_hold (%0d,%0d): got %0d expected %0d", a, b, hold_seen, last_res);
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL done_timeout (%0d,%0d): no done within %0d cycles", a, b, cyc);
        end
        e = sb.pop_front();
        tests++;
        if (result !== e.res) begin
            fails++;
            $display("FAIL result (%0d,%0d): got %0d expected %0d", a, b, result, e.res);
        end
        tests++;
        if (got && cyc != e.lat) begin
            fails++;
            $display("FAIL latency (%0d,%0d): got %0d edges expected %0d", a, b, cyc, e.lat);
        end
        last_res = e.res;
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL done_one_cycle (%0d,%0d): got %b expected 0", a, b, done);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        a_in    = 32'd0;
        b_in    = 32'd0;
        #15;
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL reset_done: got %b expected 0", done);
        end
        tests++;
        if (result !== 32'd0) begin
            fails++;
            $display("FAIL reset_result: got %0d expected 0", result);
        end
`ifdef GCD_BUSY_EN
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
`endif
        reset_n = 1'b1;
        last_res = 32'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run_op(32'd12, 32'd18, 1'b0);
        run_op(32'd7, 32'd7, 1'b0);
        run_op(32'd0, 32'd5, 1'b0);
        run_op(32'd0, 32'd0, 1'b0);
        run_op(32'd21, 32'd0, 1'b0);
    endtask

    task automatic test_mid_start();
        run_op(32'd1, 32'd100, 1'b1);
    endtask

    task automatic test_reset_midrun();
        bit seen;
        start = 1'b1;
        a_in  = 32'd1;
        b_in  = 32'd100;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL abort_done: got %b expected 0", done);
        end
        tests++;
        if (result !== 32'd0) begin
            fails++;
            $display("FAIL abort_result: got %0d expected 0", result);
        end
        @(negedge clk);
        reset_n = 1'b1;
        last_res = 32'd0;
        seen = 0;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen = 1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL abort_late_done: got done=1 expected none");
        end
        run_op(32'd48, 32'd36, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_op(32'd48, 32'd36, 1'b0);
        @(posedge clk); #1;
        run_op(32'd35, 32'd14, 1'b0);
        @(posedge clk); #1;
        run_op(32'd1071, 32'd462, 1'b0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        last_res = 32'd0;
        test_reset();
        test_basic();
        test_mid_start();
        test_reset_midrun();
        test_back_to_back();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
